demux_1_8_seq: RTL and testbench

//  Registered 1-to-8 demultiplexer / serial-to-parallel collector; inverse of the 8:1 bit-select mux.

---
 rtl/demux_1_8_seq.sv | 105 ++++++++++
 tb/tb_demux_1_8_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/demux_1_8_seq.sv
// Registered 1-to-WIDTH demultiplexer / serial-to-parallel collector.
// Supports addressed single-bit writes in IDLE and counted stream capture with a valid/ready word handoff.
module demux_1_8_seq #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = 3,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic [SEL_W-1:0] sel,
    input  logic             load,
    input  logic             start,
    input  logic             in_valid,
    output logic [WIDTH-1:0] f,
    output logic             f_valid,
    input  logic             f_ready,
    output logic             busy,
    output logic [SEL_W-1:0] bit_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W:0]   WIDTH_EXT = (SEL_W + 1)'(WIDTH);

    state_t           state_p0, state_p1;
    logic [WIDTH-1:0] f_p0, f_p1;
    logic             f_valid_p0, f_valid_p1;
    logic [SEL_W-1:0] bit_cnt_p0, bit_cnt_p1;
    logic             busy_p1;
    logic             sel_in_range;
    logic [SEL_W-1:0] stream_idx;

    // Non-power-of-2 WIDTH leaves some sel codes with no lane behind them.
    assign sel_in_range = ({1'b0, sel} < WIDTH_EXT);
    assign stream_idx   = LSB_FIRST ? bit_cnt_p1 : (LAST_IDX - bit_cnt_p1);

    // Stage p0: next-state and next-output decode
    always_comb begin
        state_p0   = state_p1;
        f_p0       = f_p1;
        f_valid_p0 = f_valid_p1;
        bit_cnt_p0 = bit_cnt_p1;
        case (state_p1)
            IDLE: begin
                if (start) begin
                    state_p0   = CAPTURE;
                    bit_cnt_p0 = '0;
                end else if (load && sel_in_range) begin
                    f_p0[sel] = d;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    f_p0[stream_idx] = d;
                    if (bit_cnt_p1 == LAST_IDX) begin
                        state_p0   = DONE;
                        bit_cnt_p0 = '0;
                        f_valid_p0 = 1'b1;
                    end else begin
                        bit_cnt_p0 = bit_cnt_p1 + SEL_W'(1);
                    end
                end
            end
            DONE: begin
                // The word stays in f after the handshake; only the valid flag drops.
                if (f_ready) begin
                    state_p0   = IDLE;
                    f_valid_p0 = 1'b0;
                end
            end
            default: begin
                state_p0 = IDLE;
            end
        endcase
    end

    // Stage p1: output registers (f is cleared on reset so a discarded partial word never leaks)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1   <= IDLE;
            f_p1       <= '0;
            f_valid_p1 <= 1'b0;
            bit_cnt_p1 <= '0;
            busy_p1    <= 1'b0;
        end else begin
            state_p1   <= state_p0;
            f_p1       <= f_p0;
            f_valid_p1 <= f_valid_p0;
            bit_cnt_p1 <= bit_cnt_p0;
            busy_p1    <= (state_p0 != IDLE);
        end
    end

    assign f       = f_p1;
    assign f_valid = f_valid_p1;
    assign busy    = busy_p1;
    assign bit_cnt = bit_cnt_p1;

endmodule

// File: tb/tb_demux_1_8_seq.sv
// Directed bench for demux_1_8_seq: a word-level reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_demux_1_8_seq;

    localparam int WIDTH = 8;
    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             d = 1'b0;
    logic [SEL_W-1:0] sel = '0;
    logic             load = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             f_ready = 1'b0;
    logic [WIDTH-1:0] f;
    logic             f_valid;
    logic             busy;
    logic [SEL_W-1:0] bit_cnt;

    int checks = 0;
    int failures = 0;

    demux_1_8_seq #(.WIDTH(WIDTH), .SEL_W(SEL_W), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .d(d), .sel(sel), .load(load), .start(start),
        .in_valid(in_valid), .f(f), .f_valid(f_valid), .f_ready(f_ready),
        .busy(busy), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = idle, 1 = collecting, 2 = word held for consumer.
    // Collected stream bits are kept in a queue; the word is rebuilt from it.
    int         m_mode = 0;
    bit [7:0]   m_word = '0;
    bit         m_vld = 1'b0;
    bit         m_live = 1'b0;
    bit         m_bits[$];

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0;
            m_word = '0;
            m_vld  = 1'b0;
            m_bits.delete();
            m_live = 1'b1;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode = 1;
                m_bits.delete();
            end else if (load && int'(sel) < WIDTH) begin
                m_word[sel] = d;
            end
        end else if (m_mode == 1) begin
            if (in_valid) begin
                m_bits.push_back(d);
                m_word[m_bits.size() - 1] = d;
                if (m_bits.size() == WIDTH) begin
                    m_mode = 2;
                    m_vld  = 1'b1;
                    m_bits.delete();
                end
            end
        end else if (f_ready) begin
            m_mode = 0;
            m_vld  = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_f", 32'(f), 32'(m_word));
            chk("model_f_valid", 32'(f_valid), 32'(m_vld));
            chk("model_busy", 32'(busy), 32'(m_mode != 0));
            chk("model_bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load = 1'b0; start = 1'b0; in_valid = 1'b0; f_ready = 1'b0; d = 1'b0; sel = '0;
    endtask

    // Streams w[0] first; a set bit in gaps inserts one in_valid=0 cycle after that bit.
    task automatic send_word(input logic [7:0] w, input logic [7:0] gaps);
        for (int i = 0; i < WIDTH; i++) begin
            in_valid = 1'b1; d = w[i];
            tick();
            if (gaps[i]) begin
                in_valid = 1'b0; d = ~w[i];
                tick();
                chk("stall_bit_cnt", 32'(bit_cnt), 32'(i + 1));
            end
        end
        in_valid = 1'b0; d = 1'b0;
    endtask

    initial begin
        idle_inputs();
        // 1) reset dominates load/start
        rst = 1'b1; d = 1'b1; load = 1'b1; start = 1'b1;
        tick(); tick();
        chk("rst_f", 32'(f), 32'h00);
        chk("rst_f_valid", 32'(f_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_bit_cnt", 32'(bit_cnt), 32'h0);
        rst = 1'b0; idle_inputs();
        tick();

        // 2) addressed writes
        load = 1'b1; sel = 3'b110; d = 1'b1; tick();
        chk("addr_f_40", 32'(f), 32'h40);
        sel = 3'b000; d = 1'b1; tick();
        chk("addr_f_41", 32'(f), 32'h41);
        sel = 3'b110; d = 1'b0; tick();
        chk("addr_f_01", 32'(f), 32'h01);
        idle_inputs(); tick();

        // 3) plain stream 1,0,1,1,0,0,1,0
        start = 1'b1; tick(); start = 1'b0;
        chk("cap_busy", 32'(busy), 32'h1);
        send_word(8'h4D, 8'h00);
        chk("word_f", 32'(f), 32'h4D);
        chk("word_f_valid", 32'(f_valid), 32'h1);
        f_ready = 1'b1; tick(); f_ready = 1'b0;
        chk("hs_f_valid", 32'(f_valid), 32'h0);
        chk("hs_f", 32'(f), 32'h4D);
        chk("hs_busy", 32'(busy), 32'h0);

        // 4) stalls after bits 2 and 5, then backpressure with ignored load/start
        load = 1'b1; sel = 3'd0; d = 1'b0; tick(); load = 1'b0;
        chk("pre_f", 32'(f), 32'h4C);
        start = 1'b1; tick(); start = 1'b0;
        send_word(8'h4D, 8'b0001_0010);
        chk("stall_word_f", 32'(f), 32'h4D);
        for (int i = 0; i < 5; i++) begin
            load = 1'b1; sel = 3'(i); d = ~f[i]; start = i[0];
            tick();
            chk("bp_f", 32'(f), 32'h4D);
            chk("bp_f_valid", 32'(f_valid), 32'h1);
            chk("bp_busy", 32'(busy), 32'h1);
        end
        idle_inputs();
        f_ready = 1'b1; tick(); f_ready = 1'b0;
        chk("bp_release", 32'(f_valid), 32'h0);

        // 5) start beats load; start during the handshake is ignored
        start = 1'b1; load = 1'b1; sel = 3'd2; d = 1'b0; tick();
        idle_inputs();
        chk("coll_busy", 32'(busy), 32'h1);
        chk("coll_f2", 32'(f), 32'h4D);
        send_word(8'hF0, 8'h00);
        chk("coll_word", 32'(f), 32'hF0);
        f_ready = 1'b1; start = 1'b1; tick();
        idle_inputs();
        chk("coll_hs_busy", 32'(busy), 32'h0);
        tick();
        chk("coll_no_cap", 32'(busy), 32'h0);

        // 6) reset mid-capture, then a fresh stream
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; d = 1'b1; tick();
        end
        chk("mid_bit_cnt", 32'(bit_cnt), 32'h4);
        in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_f", 32'(f), 32'h00);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_cnt", 32'(bit_cnt), 32'h0);
        start = 1'b1; tick(); start = 1'b0;
        send_word(8'hA5, 8'h00);
        chk("a5_f", 32'(f), 32'hA5);
        chk("a5_f_valid", 32'(f_valid), 32'h1);
        f_ready = 1'b1; tick();
        idle_inputs(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
